// File: rtl/data_buffer.sv
`default_nettype none
// ============================================================================
// Module      : data_buffer
// Description : Circular byte FIFO between the AHB-lite slave (1/2/4-byte
//               little-endian accesses) and the USB packet side (1 byte).
// Revision    : 1.0 - initial release
// ============================================================================
module data_buffer #(
    parameter int DEPTH = 64
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        clear,
    input  logic                        store_tx_data,
    input  logic [31:0]                 tx_data,
    input  logic [1:0]                  data_size,
    input  logic                        get_rx_data,
    output logic [31:0]                 rx_data,
    input  logic                        store_rx_packet_data,
    input  logic [7:0]                  rx_packet_data,
    input  logic                        get_tx_packet_data,
    output logic [7:0]                  tx_packet_data,
    output logic [$clog2(DEPTH):0]      buffer_occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_rx_data;
    logic [7:0]    r_tx_packet_data;

    logic [CW-1:0] w_ahb_n;
    logic [CW-1:0] w_push_n;
    logic [CW-1:0] w_pop_n;
    logic [CW-1:0] w_free;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic [CW-1:0] w_push_amt;
    logic [CW-1:0] w_pop_amt;
    logic [7:0]    w_wr_byte [4];
    logic [31:0]   w_rd_word;

    always_comb begin
        w_ahb_n = CW'(4);
        case (data_size)
            2'd0:    w_ahb_n = CW'(1);
            2'd1:    w_ahb_n = CW'(2);
            default: w_ahb_n = CW'(4);
        endcase
    end

    // AHB strobes take priority; USB accesses are always a single byte
    assign w_push_n   = store_tx_data ? w_ahb_n : (store_rx_packet_data ? CW'(1) : '0);
    assign w_pop_n    = get_rx_data   ? w_ahb_n : (get_tx_packet_data   ? CW'(1) : '0);
    assign w_free     = c_FULL - r_count;
    assign w_push_ok  = !clear && (w_push_n != '0) && (w_free  >= w_push_n);
    assign w_pop_ok   = !clear && (w_pop_n  != '0) && (r_count >= w_pop_n);
    assign w_push_amt = w_push_ok ? w_push_n : '0;
    assign w_pop_amt  = w_pop_ok  ? w_pop_n  : '0;

    always_comb begin
        w_wr_byte[0] = store_tx_data ? tx_data[7:0] : rx_packet_data;
        w_wr_byte[1] = tx_data[15:8];
        w_wr_byte[2] = tx_data[23:16];
        w_wr_byte[3] = tx_data[31:24];
    end

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (CW'(i) < w_pop_n)
                w_rd_word[8*i +: 8] = r_mem[r_rd_ptr + AW'(i)];
        end
    end

    // Storage carries no reset: contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_push_ok && (CW'(i) < w_push_n))
                r_mem[r_wr_ptr + AW'(i)] <= w_wr_byte[i];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_rx_data        <= '0;
            r_tx_packet_data <= '0;
        end else if (clear) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_rx_data        <= '0;
            r_tx_packet_data <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_push_amt[AW-1:0];
            r_rd_ptr <= r_rd_ptr + w_pop_amt[AW-1:0];
            r_count  <= r_count + w_push_amt - w_pop_amt;
            if (w_pop_ok && get_rx_data)
                r_rx_data <= w_rd_word;
            else if (w_pop_ok)
                r_tx_packet_data <= r_mem[r_rd_ptr];
        end
    end

    assign rx_data          = r_rx_data;
    assign tx_packet_data   = r_tx_packet_data;
    assign buffer_occupancy = r_count;

endmodule
`default_nettype wire

// File: tb/tb_data_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_buffer
// Description : Directed self-checking bench for data_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_buffer;

    logic        tb_clk = 1'b0;
    logic        n_rst;
    logic        clear;
    logic        store_tx_data;
    logic [31:0] tx_data;
    logic [1:0]  data_size;
    logic        get_rx_data;
    logic [31:0] rx_data;
    logic        store_rx_packet_data;
    logic [7:0]  rx_packet_data;
    logic        get_tx_packet_data;
    logic [7:0]  tx_packet_data;
    logic [6:0]  buffer_occupancy;

    int checks = 0;
    int errors = 0;

    always #5 tb_clk = ~tb_clk;

    data_buffer #(.DEPTH(64)) dut (
        .clk                  (tb_clk),
        .n_rst                (n_rst),
        .clear                (clear),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .data_size            (data_size),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .buffer_occupancy     (buffer_occupancy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic idle();
        clear = 0; store_tx_data = 0; get_rx_data = 0;
        store_rx_packet_data = 0; get_tx_packet_data = 0;
    endtask

    task automatic ahb_push(input logic [31:0] d, input logic [1:0] sz);
        store_tx_data = 1; tx_data = d; data_size = sz;
        cycle();
        idle();
    endtask

    task automatic ahb_pop(input logic [1:0] sz);
        get_rx_data = 1; data_size = sz;
        cycle();
        idle();
    endtask

    task automatic usb_push(input logic [7:0] b);
        store_rx_packet_data = 1; rx_packet_data = b;
        cycle();
        idle();
    endtask

    task automatic usb_pop();
        get_tx_packet_data = 1;
        cycle();
        idle();
    endtask

    initial begin
        logic [7:0] exp_bytes [4];
        n_rst = 0; tx_data = '0; data_size = '0; rx_packet_data = '0;
        idle();
        #12;
        check("reset_occ", {25'd0, buffer_occupancy}, 32'd0);
        check("reset_rx",  rx_data, 32'd0);
        check("reset_tx",  {24'd0, tx_packet_data}, 32'd0);
        @(negedge tb_clk);
        n_rst = 1;
        @(posedge tb_clk); #1;

        // AHB word in, four USB bytes out, little-endian order
        ahb_push(32'hDDCCBBAA, 2'd2);
        check("push4_occ", {25'd0, buffer_occupancy}, 32'd4);
        exp_bytes[0] = 8'hAA; exp_bytes[1] = 8'hBB; exp_bytes[2] = 8'hCC; exp_bytes[3] = 8'hDD;
        for (int i = 0; i < 4; i++) begin
            usb_pop();
            check("usb_pop_byte", {24'd0, tx_packet_data}, {24'd0, exp_bytes[i]});
        end
        check("drain4_occ", {25'd0, buffer_occupancy}, 32'd0);

        // USB bytes in, AHB halfword out; short pop dropped
        usb_push(8'h11); usb_push(8'h22); usb_push(8'h33);
        check("usb3_occ", {25'd0, buffer_occupancy}, 32'd3);
        ahb_pop(2'd1);
        check("pop2_rx",  rx_data, 32'h00002211);
        check("pop2_occ", {25'd0, buffer_occupancy}, 32'd1);
        ahb_pop(2'd1);
        check("underflow_rx",  rx_data, 32'h00002211);
        check("underflow_occ", {25'd0, buffer_occupancy}, 32'd1);
        usb_pop();
        check("last_byte_tx", {24'd0, tx_packet_data}, 32'h33);
        usb_pop();
        check("empty_pop_tx",  {24'd0, tx_packet_data}, 32'h33);
        check("empty_pop_occ", {25'd0, buffer_occupancy}, 32'd0);

        // Fill to 64, overflow attempts dropped, drain in order
        for (int j = 0; j < 16; j++)
            ahb_push({8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)}, 2'd2);
        check("full_occ", {25'd0, buffer_occupancy}, 32'd64);
        ahb_push(32'hFFFFFFFF, 2'd2);
        check("ovf_ahb_occ", {25'd0, buffer_occupancy}, 32'd64);
        usb_push(8'hEE);
        check("ovf_usb_occ", {25'd0, buffer_occupancy}, 32'd64);
        for (int k = 0; k < 64; k++) begin
            usb_pop();
            check("drain_byte", {24'd0, tx_packet_data}, k);
        end
        check("drained_occ", {25'd0, buffer_occupancy}, 32'd0);

        // Restart at pointer 0, walk pointers to 62, straddle 63->0
        clear = 1; cycle(); idle();
        for (int k = 0; k < 62; k++) begin
            usb_push(8'(k)); usb_pop();
        end
        check("walk_occ", {25'd0, buffer_occupancy}, 32'd0);
        ahb_push(32'h44332211, 2'd2);
        check("wrap_push_occ", {25'd0, buffer_occupancy}, 32'd4);
        ahb_pop(2'd2);
        check("wrap_rx",  rx_data, 32'h44332211);
        check("wrap_occ", {25'd0, buffer_occupancy}, 32'd0);

        // Simultaneous push/pop and strobe priorities
        ahb_push(32'h04030201, 2'd2);
        usb_push(8'h05);
        check("occ5", {25'd0, buffer_occupancy}, 32'd5);
        store_tx_data = 1; tx_data = 32'h000000A6; data_size = 2'd0; get_tx_packet_data = 1;
        cycle(); idle();
        check("simul_tx",  {24'd0, tx_packet_data}, 32'h01);
        check("simul_occ", {25'd0, buffer_occupancy}, 32'd5);
        store_tx_data = 1; tx_data = 32'h00000077; data_size = 2'd0;
        store_rx_packet_data = 1; rx_packet_data = 8'h88;
        cycle(); idle();
        check("push_prio_occ", {25'd0, buffer_occupancy}, 32'd6);
        get_rx_data = 1; data_size = 2'd0; get_tx_packet_data = 1;
        cycle(); idle();
        check("pop_prio_rx",  rx_data, 32'h00000002);
        check("pop_prio_tx",  {24'd0, tx_packet_data}, 32'h01);
        check("pop_prio_occ", {25'd0, buffer_occupancy}, 32'd5);
        ahb_pop(2'd3);
        check("size3_rx",  rx_data, 32'hA6050403);
        check("size3_occ", {25'd0, buffer_occupancy}, 32'd1);
        usb_pop();
        check("prio_byte_tx", {24'd0, tx_packet_data}, 32'h77);

        // Clear overrides concurrent strobes
        usb_push(8'h12);
        clear = 1; store_tx_data = 1; tx_data = 32'hFFFFFFFF; data_size = 2'd2;
        get_tx_packet_data = 1;
        cycle(); idle();
        check("clear_occ", {25'd0, buffer_occupancy}, 32'd0);
        check("clear_rx",  rx_data, 32'd0);
        check("clear_tx",  {24'd0, tx_packet_data}, 32'd0);
        usb_push(8'hC3);
        ahb_pop(2'd0);
        check("post_clear_rx", rx_data, 32'h000000C3);

        // Asynchronous reset between clock edges
        ahb_push(32'h5A5A5A5A, 2'd2);
        usb_pop();
        ahb_pop(2'd0);
        check("pre_rst_occ", {25'd0, buffer_occupancy}, 32'd2);
        store_tx_data = 1; tx_data = 32'h01010101; data_size = 2'd2;
        #2 n_rst = 0;
        #1;
        check("async_occ", {25'd0, buffer_occupancy}, 32'd0);
        check("async_rx",  rx_data, 32'd0);
        check("async_tx",  {24'd0, tx_packet_data}, 32'd0);
        idle();
        cycle();
        check("held_rst_occ", {25'd0, buffer_occupancy}, 32'd0);
        @(negedge tb_clk);
        n_rst = 1;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
